universal_serial_adder: RTL and testbench

UNIVERSAL_SERIAL_ADDER -- requirements
Module: universal_serial_adder

---
 rtl/universal_serial_adder_if.sv | 27 ++
 rtl/universal_serial_adder.sv | 124 ++++++++++++
 tb/tb_universal_serial_adder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/universal_serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The ovf signal exists only when UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN is defined.
interface universal_serial_adder_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             op;
    logic [WIDTH-1:0] R;
    logic             carry;
    logic             busy;
    logic             done;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
    logic             ovf;

    modport master (output start, output A, output B, output op,
                    input R, input carry, input busy, input done, input ovf);
    modport slave  (input start, input A, input B, input op,
                    output R, output carry, output busy, output done, output ovf);
`else
    modport master (output start, output A, output B, output op,
                    input R, input carry, input busy, input done);
    modport slave  (input start, input A, input B, input op,
                    output R, output carry, output busy, output done);
`endif
endinterface

// File: rtl/universal_serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Computes (A + B + op) mod 2^WIDTH with carry-out; results appear in a one-cycle DONE state.
// Optional signed-overflow flag: define UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN.
module universal_serial_adder #(
    parameter int WIDTH = 4
) (
    input logic                      clk,
    input logic                      rst,
    universal_serial_adder_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;
    logic             bit_sum;
    logic             bit_cout;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    // Single full-adder cell working on the current LSBs and the running carry
    always_comb begin
        bit_sum  = a_q[0] ^ b_q[0] ^ cy_q;
        bit_cout = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);
    end

    // Next-state and datapath update: latch in IDLE, shift one bit per ADD clock, publish on DONE entry
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_sr_d = sum_sr_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        carry_d  = carry_q;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    cy_d    = bus.op;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                cy_d     = bit_cout;
                sum_sr_d = {bit_sum, sum_sr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    r_d     = {bit_sum, sum_sr_q[WIDTH-1:1]};
                    carry_d = bit_cout;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
                    ovf_d   = cy_q ^ bit_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sr_q <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            carry_q  <= 1'b0;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_sr_q <= sum_sr_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            carry_q  <= carry_d;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.R     = r_q;
    assign bus.carry = carry_q;
    assign bus.busy  = (state_q == ADD);
    assign bus.done  = (state_q == DONE);
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_universal_serial_adder.sv
// Self-checking bench for universal_serial_adder against an arithmetic reference model.
module tb_universal_serial_adder;
    localparam int W = 4;
    localparam int TIMEOUT = 50;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    universal_serial_adder_if #(.WIDTH(W)) bus ();

    universal_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision sum, low W bits are R, bit W is carry
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
        int s;
        s = int'(a) + int'(b) + int'(o);
        return s[W:0];
    endfunction

    // Reference signed overflow: like-signed operands giving an opposite-signed result
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
        logic [W:0] s;
        s = ref_sum(a, b, o);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Launch one operation, scramble inputs while it runs, and wait (bounded) for done
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                          output int lat, output logic r_changed);
        logic [W-1:0] r_first;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.op = o;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        r_first = bus.R;
        r_changed = 1'b0;
        lat = 0;
        while (!bus.done && lat < TIMEOUT) begin
            @(negedge clk);
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            bus.op = 1'($urandom);
            bus.start = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
            if (!bus.done && bus.R !== r_first) r_changed = 1'b1;
        end
        bus.start = 1'b0;
    endtask

    // Step past the DONE cycle back to IDLE
    task automatic finish_op();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.A = 4'd9;
        bus.B = 4'd9;
        bus.op = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.R !== '0) $display("[TB] FAIL reset_R: got %0d expected 0", bus.R); else passes++;
        checks++;
        if (bus.carry !== 1'b0) $display("[TB] FAIL reset_carry: got %b expected 0", bus.carry); else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
        checks++;
        if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.done); else passes++;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
        checks++;
        if (bus.ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf); else passes++;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{4'd3, 4'd15, 4'd15, 4'd7, 4'd0};
        logic [W-1:0] vb [5] = '{4'd5, 4'd1,  4'd15, 4'd7, 4'd0};
        logic         vo [5] = '{1'b0, 1'b0,  1'b1,  1'b1, 1'b1};
        logic [W-1:0] er [5] = '{4'd8, 4'd0,  4'd15, 4'd15, 4'd1};
        logic         ec [5] = '{1'b0, 1'b1,  1'b1,  1'b0, 1'b0};
        int   lat;
        logic rc;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vo[i], lat, rc);
            checks++;
            if (lat !== W) $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, W); else passes++;
            checks++;
            if (bus.R !== er[i]) $display("[TB] FAIL dir%0d_R: got %0d expected %0d", i, bus.R, er[i]); else passes++;
            checks++;
            if (bus.carry !== ec[i]) $display("[TB] FAIL dir%0d_carry: got %b expected %b", i, bus.carry, ec[i]); else passes++;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
            checks++;
            if (bus.ovf !== ref_ovf(va[i], vb[i], vo[i]))
                $display("[TB] FAIL dir%0d_ovf: got %b expected %b", i, bus.ovf, ref_ovf(va[i], vb[i], vo[i]));
            else passes++;
`endif
            finish_op();
            checks++;
            if (bus.done !== 1'b0) $display("[TB] FAIL dir%0d_done_pulse: got %b expected 0", i, bus.done); else passes++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         o;
        logic [W:0]   exp_s;
        int   lat;
        logic rc;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            o = 1'($urandom);
            exp_s = ref_sum(a, b, o);
            run_op(a, b, o, lat, rc);
            checks++;
            if (lat !== W) $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", i, lat, W); else passes++;
            checks++;
            if (rc !== 1'b0) $display("[TB] FAIL rnd%0d_R_hold: got %b expected 0", i, rc); else passes++;
            checks++;
            if ({bus.carry, bus.R} !== exp_s)
                $display("[TB] FAIL rnd%0d_sum: got carry=%b R=%0d expected carry=%b R=%0d (A=%0d B=%0d op=%b)",
                         i, bus.carry, bus.R, exp_s[W], exp_s[W-1:0], a, b, o);
            else passes++;
`ifdef UNIVERSAL_SERIAL_ADDER_OVERFLOW_FLAG_EN
            checks++;
            if (bus.ovf !== ref_ovf(a, b, o))
                $display("[TB] FAIL rnd%0d_ovf: got %b expected %b", i, bus.ovf, ref_ovf(a, b, o));
            else passes++;
`endif
            finish_op();
        end
    endtask

    task automatic test_busy_lockout();
        logic [W-1:0] a_at [13];
        logic [W-1:0] b;
        logic         o;
        logic [W:0]   exp1;
        logic [W:0]   exp2;
        logic         exp_busy;
        logic         exp_done;
        int           pulses;
        b = W'($urandom);
        o = 1'($urandom);
        for (int e = 0; e < 13; e++) a_at[e] = W'($urandom);
        exp1 = ref_sum(a_at[0], b, o);
        exp2 = ref_sum(a_at[W+2], b, o);
        pulses = 0;
        for (int e = 0; e < 13; e++) begin
            @(negedge clk);
            bus.A = a_at[e];
            bus.B = b;
            bus.op = o;
            bus.start = (e < 8);
            @(posedge clk);
            #1;
            exp_busy = (e <= W - 1) || (e >= W + 2 && e <= 2 * W + 1);
            exp_done = (e == W) || (e == 2 * W + 2);
            if (bus.done && e < 8) pulses++;
            checks++;
            if (bus.busy !== exp_busy) $display("[TB] FAIL lock_busy_e%0d: got %b expected %b", e, bus.busy, exp_busy); else passes++;
            checks++;
            if (bus.done !== exp_done) $display("[TB] FAIL lock_done_e%0d: got %b expected %b", e, bus.done, exp_done); else passes++;
            if (e == W) begin
                checks++;
                if ({bus.carry, bus.R} !== exp1)
                    $display("[TB] FAIL lock_first_sum: got %0d expected %0d", {bus.carry, bus.R}, exp1);
                else passes++;
            end
            if (e == 2 * W + 2) begin
                checks++;
                if ({bus.carry, bus.R} !== exp2)
                    $display("[TB] FAIL lock_second_sum: got %0d expected %0d", {bus.carry, bus.R}, exp2);
                else passes++;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (pulses !== 1) $display("[TB] FAIL lock_pulse_count: got %0d expected 1", pulses); else passes++;
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp_s;
        int   lat;
        logic rc;
        int   seen_done;
        run_op(4'd6, 4'd7, 1'b1, lat, rc);
        finish_op();
        @(negedge clk);
        bus.A = 4'd12;
        bus.B = 4'd9;
        bus.op = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.R !== '0) $display("[TB] FAIL midrst_R: got %0d expected 0", bus.R); else passes++;
        checks++;
        if (bus.carry !== 1'b0) $display("[TB] FAIL midrst_carry: got %b expected 0", bus.carry); else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", bus.busy); else passes++;
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) $display("[TB] FAIL midrst_no_done: got %0d expected 0", seen_done); else passes++;
        a = W'($urandom);
        b = W'($urandom);
        exp_s = ref_sum(a, b, 1'b1);
        run_op(a, b, 1'b1, lat, rc);
        checks++;
        if ({bus.carry, bus.R} !== exp_s)
            $display("[TB] FAIL midrst_fresh_sum: got %0d expected %0d", {bus.carry, bus.R}, exp_s);
        else passes++;
        finish_op();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.op = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_busy_lockout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
